// File: rtl/audio_pkg.sv
// Shared constants and the slot bit-select helper for the I2S transmitter.
package audio_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FRAME_BCKS = 64;
    localparam int SLOT_BCKS  = 32;
    localparam int CNT_W      = $clog2(FRAME_BCKS);
    localparam int IDX_W      = $clog2(SAMPLE_W);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } bit_sel_t;

    // Position 0 of each slot is the I2S one-bit delay; positions 1..SAMPLE_W carry MSB..LSB.
    function automatic bit_sel_t i2s_bit_sel(input logic [CNT_W-1:0] b);
        bit_sel_t         sel;
        logic [CNT_W-1:0] off;
        off       = {1'b0, b[CNT_W-2:0]};
        sel.valid = (off >= CNT_W'(1)) && (off <= CNT_W'(SAMPLE_W));
        sel.idx   = IDX_W'(CNT_W'(SAMPLE_W) - off);
        return sel;
    endfunction

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Sample source / DAC pin bundle of the I2S transmitter.
// The mute signal exists only when AUDIO_TX_MUTE_EN is defined.
interface audio_i2s_tx_if;
    import audio_pkg::*;

    logic signed [SAMPLE_W-1:0] left_audio;
    logic signed [SAMPLE_W-1:0] right_audio;
    logic                       next_sample;
    logic                       i2s_bck;
    logic                       i2s_lrck;
    logic                       i2s_data;
`ifdef AUDIO_TX_MUTE_EN
    logic                       mute;
`endif

    modport master (
`ifdef AUDIO_TX_MUTE_EN
        output mute,
`endif
        output left_audio, right_audio,
        input  next_sample, i2s_bck, i2s_lrck, i2s_data
    );

    modport slave (
`ifdef AUDIO_TX_MUTE_EN
        input  mute,
`endif
        input  left_audio, right_audio,
        output next_sample, i2s_bck, i2s_lrck, i2s_data
    );

endinterface

// File: rtl/audio_bck_div.sv
// Bit-clock divider: bck toggles every CLK_DIV clk; the strobes mark the clk whose edge toggles bck.
module audio_bck_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic bck,
    output logic bck_fall,
    output logic bck_rise
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign bck_fall = tick & bck;
    assign bck_rise = tick & ~bck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bck     <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                bck <= ~bck;
            end
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: latches left/right at each 64-BCK frame boundary and shifts them out MSB first.
// Define AUDIO_TX_MUTE_EN to add a mute input that zeroes whole frames.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input logic           clk,
    input logic           rst_n,
    audio_i2s_tx_if.slave aif
);
    logic                bck;
    logic                bck_fall;
    logic                rise_unused;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    bit_nxt;
    logic [SAMPLE_W-1:0] hold_l;
    logic [SAMPLE_W-1:0] hold_r;
    logic [SAMPLE_W-1:0] load_l;
    logic [SAMPLE_W-1:0] load_r;
    logic                next_sample;
    logic                lrck;
    logic                data;
    logic                data_nxt;
    logic                wrap;
    bit_sel_t            sel;

    audio_bck_div #(.CLK_DIV(CLK_DIV)) u_bck_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .bck      (bck),
        .bck_fall (bck_fall),
        .bck_rise (rise_unused)
    );

    assign bit_nxt = bit_cnt + CNT_W'(1);
    assign wrap    = bck_fall && (bit_cnt == CNT_W'(FRAME_BCKS - 1));

`ifdef AUDIO_TX_MUTE_EN
    assign load_l = aif.mute ? '0 : aif.left_audio;
    assign load_r = aif.mute ? '0 : aif.right_audio;
`else
    assign load_l = aif.left_audio;
    assign load_r = aif.right_audio;
`endif

    // Data is computed for the period being entered, so it changes together with the BCK fall.
    always_comb begin
        sel      = i2s_bit_sel(bit_nxt);
        data_nxt = 1'b0;
        if (sel.valid) begin
            data_nxt = bit_nxt[CNT_W-1] ? hold_r[sel.idx] : hold_l[sel.idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            hold_l      <= '0;
            hold_r      <= '0;
            next_sample <= 1'b0;
            lrck        <= 1'b0;
            data        <= 1'b0;
        end else begin
            next_sample <= wrap;
            if (bck_fall) begin
                bit_cnt <= bit_nxt;
                lrck    <= bit_nxt[CNT_W-1];
                data    <= data_nxt;
            end
            if (wrap) begin
                hold_l <= load_l;
                hold_r <= load_r;
            end
        end
    end

    assign aif.next_sample = next_sample;
    assign aif.i2s_bck     = bck;
    assign aif.i2s_lrck    = lrck;
    assign aif.i2s_data    = data;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: CLK_DIV=4 and CLK_DIV=1 instances checked every cycle against an arithmetic model.
module tb_audio_i2s_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n;
    int   checks = 0;
    int   fails = 0;

    logic [15:0] m4_l, m4_r, m1_l, m1_r;
    logic [15:0] psg_l [0:15];
    logic [15:0] psg_r [0:15];

    audio_i2s_tx_if aif4 ();
    audio_i2s_tx_if aif1 ();

    audio_i2s_tx #(.CLK_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .aif(aif4));
    audio_i2s_tx #(.CLK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .aif(aif1));

    always #5 clk = ~clk;

    // n = number of clk rising edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s n=%0d: got %h, expected %h", name, n, act, exp);
        end
    endtask

    // Expected {next_sample, bck, lrck, data} after nn edges, from the frame arithmetic.
    function automatic logic [3:0] model_out(input int nn, input int d,
                                             input logic [15:0] hl, input logic [15:0] hr);
        int   b;
        logic bk, lr, ns, dt;
        bk = ((nn / d) % 2) == 1;
        b  = (nn / (2 * d)) % 64;
        lr = (b >= 32);
        ns = (nn > 0) && ((nn % (128 * d)) == 0);
        dt = 1'b0;
        if (b >= 1 && b <= 16)       dt = hl[16 - b];
        else if (b >= 33 && b <= 48) dt = hr[48 - b];
        return {ns, bk, lr, dt};
    endfunction

    // Model sample capture: inputs are taken at the edge completing each 128*CLK_DIV block.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4_l <= '0; m4_r <= '0; m1_l <= '0; m1_r <= '0;
        end else begin
            if (((n + 1) % 512) == 0) begin
`ifdef AUDIO_TX_MUTE_EN
                m4_l <= aif4.mute ? 16'h0 : aif4.left_audio;
                m4_r <= aif4.mute ? 16'h0 : aif4.right_audio;
`else
                m4_l <= aif4.left_audio;
                m4_r <= aif4.right_audio;
`endif
            end
            if (((n + 1) % 128) == 0) begin
                m1_l <= aif1.left_audio;
                m1_r <= aif1.right_audio;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_div4", {28'h0, aif4.next_sample, aif4.i2s_bck, aif4.i2s_lrck, aif4.i2s_data},
            {28'h0, model_out(n, 4, m4_l, m4_r)});
        chk("cyc_div1", {28'h0, aif1.next_sample, aif1.i2s_bck, aif1.i2s_lrck, aif1.i2s_data},
            {28'h0, model_out(n, 1, m1_l, m1_r)});
    end

    task automatic wait_n(input int target);
        int g = 0;
        while (n < target && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk("wait_reach", n, target);
    endtask

    task automatic wait_strobe(input bit one, output int base);
        base = -1;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if ((one ? aif1.next_sample : aif4.next_sample) === 1'b1) begin
                base = n;
                break;
            end
        end
        checks++;
        if (base < 0) begin
            fails++;
            $display("FAIL strobe_timeout n=%0d: got none, expected next_sample", n);
        end
    endtask

    // Sample 16 consecutive bit periods starting at b0 while bck is high.
    task automatic get_word(input bit one, input int base, input int b0, output logic [15:0] w);
        int d = one ? 1 : 4;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            wait_n(base + 2 * d * (b0 + i) + d);
            w = {w[14:0], one ? aif1.i2s_data : aif4.i2s_data};
        end
    endtask

    // PSG-like source for the CLK_DIV=1 instance: new sample 97 clk after each strobe.
    initial begin
        int          j = 0;
        logic [31:0] v;
        aif1.left_audio  = '0;
        aif1.right_audio = '0;
`ifdef AUDIO_TX_MUTE_EN
        aif1.mute = 1'b0;
`endif
        forever begin
            @(negedge clk);
            if (aif1.next_sample === 1'b1) begin
                j++;
                repeat (96) @(posedge clk);
                @(negedge clk);
                v = $urandom;
                aif1.left_audio  = v[15:0];
                aif1.right_audio = v[31:16];
                if (j < 16) begin
                    psg_l[j] = v[15:0];
                    psg_r[j] = v[31:16];
                end
            end
        end
    end

    // Frame k of the fast instance must carry the sample produced after strobe k-1.
    initial begin
        logic [15:0] w;
        wait (rst_n === 1'b1);
        for (int k = 2; k <= 6; k++) begin
            get_word(1'b1, 128 * k, 1, w);
            chk("psg_left", w, psg_l[k-1]);
            get_word(1'b1, 128 * k, 33, w);
            chk("psg_right", w, psg_r[k-1]);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog n=%0d: got no finish, expected end of test", n);
        $fatal(1, "timeout");
    end

    initial begin
        int          base;
        logic [15:0] w;
        logic [31:0] r;
        aif4.left_audio  = 16'h8001;
        aif4.right_audio = 16'h7FFE;
`ifdef AUDIO_TX_MUTE_EN
        aif4.mute = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {aif4.next_sample, aif4.i2s_bck, aif4.i2s_lrck, aif4.i2s_data}, 4'h0);
        rst_n = 1'b1;

        // First strobe, pulse width, first-frame zeros, second frame contents
        wait_strobe(1'b0, base);
        chk("first_strobe", base, 512);
        @(negedge clk);
        chk("pulse_width", aif4.next_sample, 1'b0);
        get_word(1'b0, 512, 1, w);
        chk("frame1_left", w, 16'h8001);
        get_word(1'b0, 512, 33, w);
        chk("frame1_right", w, 16'h7FFE);
        wait_strobe(1'b0, base);
        chk("second_strobe", base, 1024);

        // Mid-frame input change must wait for the next boundary
        get_word(1'b0, 1024, 1, w);
        chk("frame2_left", w, 16'h8001);
        wait_n(1024 + 8 * 20);
        aif4.left_audio = 16'h5A5A;
        get_word(1'b0, 1024, 33, w);
        chk("frame2_right", w, 16'h7FFE);
        get_word(1'b0, 1536, 1, w);
        chk("frame3_left", w, 16'h5A5A);

        // Asynchronous reset at b=40 of frame 4
        wait_n(2048 + 8 * 40 + 2);
        chk("b40_lrck", aif4.i2s_lrck, 1'b1);
        chk("b40_data", aif4.i2s_data, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst4", {aif4.next_sample, aif4.i2s_bck, aif4.i2s_lrck, aif4.i2s_data}, 4'h0);
        chk("async_rst1", {aif1.next_sample, aif1.i2s_bck, aif1.i2s_lrck, aif1.i2s_data}, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_strobe(1'b0, base);
        chk("rst_restart", base, 512);

        // Random samples written at random points inside each frame
        for (int f = 0; f < 12; f++) begin
            wait_strobe(1'b0, base);
            repeat ($urandom_range(1, 450)) @(negedge clk);
            r = $urandom;
            aif4.left_audio  = r[15:0];
            aif4.right_audio = r[31:16];
        end

`ifdef AUDIO_TX_MUTE_EN
        wait_strobe(1'b0, base);
        aif4.left_audio  = 16'h1234;
        aif4.right_audio = 16'h1234;
        aif4.mute        = 1'b1;
        wait_strobe(1'b0, base);
        aif4.mute = 1'b0;
        get_word(1'b0, base, 1, w);
        chk("mute_left", w, 16'h0000);
        get_word(1'b0, base, 33, w);
        chk("mute_right", w, 16'h0000);
        wait_strobe(1'b0, base);
        get_word(1'b0, base, 1, w);
        chk("unmute_left", w, 16'h1234);
`endif

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
